// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and data-memory buses shared through dmem_arbiter.
interface dmem_arbiter_if;
    logic        cpu_req, cpu_we, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_last, dma_gnt;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_last, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_rdata, dma_gnt, dma_rdata,
        output mem_we, mem_addr, mem_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_last, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_rdata, dma_gnt, dma_rdata,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: same-cycle round-robin arbiter between CPU and DMA for the data memory,
// with DMA burst locking bounded by MAX_BURST beats while the CPU waits.
module dmem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] MAXB = 4'(MAX_BURST);
    logic       prio_q, prio_d, lock_q, lock_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       forced, dma_locked, drop, cpu_gnt, dma_gnt;
    always_comb begin
        forced     = lock_q && bus.cpu_req && beat_cnt_q == MAXB;
        dma_locked = lock_q && bus.dma_req;
        drop       = lock_q && !bus.dma_req;
        cpu_gnt    = forced || (!dma_locked && bus.cpu_req && (!bus.dma_req || !prio_q));
        dma_gnt    = !forced && bus.dma_req && (dma_locked || !bus.cpu_req || prio_q);
        prio_d     = cpu_gnt ? 1'b1 : (dma_gnt && bus.dma_last) ? 1'b0 : prio_q;
        lock_d     = drop ? 1'b0 : dma_gnt ? !bus.dma_last : lock_q;
        // A CPU grant restarts the count so a preempted burst gets a fresh window.
        beat_cnt_d = (drop || cpu_gnt || (dma_gnt && bus.dma_last)) ? 4'd0 :
                     !dma_gnt ? beat_cnt_q :
                     beat_cnt_q == MAXB ? MAXB : beat_cnt_q + 4'd1;
    end
    assign bus.cpu_stall = bus.cpu_req && !cpu_gnt;
    assign bus.dma_gnt   = dma_gnt;
    assign bus.mem_addr  = dma_gnt ? bus.dma_addr : bus.cpu_addr;
    assign bus.mem_wdata = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.mem_we    = (cpu_gnt && bus.cpu_we) || (dma_gnt && bus.dma_we);
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_rdata = bus.mem_rdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            beat_cnt_q <= 4'd0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule
